mult_control: RTL and testbench
===============================

MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 SHALL have parameter N, default 4, which sets the operand width and the number of Booth iterations.
REQ-002 SHALL have parameter CW, default 3, which sets the counter width; CW SHALL satisfy 2^CW > N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: level request to begin one multiplication.
REQ-006 SHALL have port q0, input, 1 bit: Q register bit 0 from the datapath.
REQ-007 SHALL have port q_1, input, 1 bit: Q[-1] extension bit from the datapath.
REQ-008 SHALL have port load_m, output, 1 bit: load enable to the M register.
REQ-009 SHALL have port load_q, output, 1 bit: load enable to the Q register.
REQ-010 SHALL have port clr_a, output, 1 bit: clear strobe for the accumulator A.
REQ-011 SHALL have port clr_q1, output, 1 bit: clear strobe for Q[-1].
REQ-012 SHALL have port add, output, 1 bit: A <= A + M strobe.
REQ-013 SHALL have port sub, output, 1 bit: A <= A - M strobe.
REQ-014 SHALL have port shift, output, 1 bit: arithmetic right-shift strobe for {A,Q,Q[-1]}.
REQ-015 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-016 SHALL have port done, output, 1 bit: high when the result is valid.
REQ-017 SHALL have port count, output, CW bits: number of iterations remaining.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, LOAD, EVAL, ARITH, SHIFT, DONE, and all strobes SHALL be decoded from registered state only.
REQ-019 IDLE: when start=1 is sampled, the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-020 LOAD: load_m, load_q, clr_a and clr_q1 SHALL be high for exactly this one cycle; count SHALL be set to N; next state SHALL be EVAL.
REQ-021 EVAL: {q0,q_1} SHALL be sampled only in this state; 10 SHALL latch op=sub and go to ARITH; 01 SHALL latch op=add and go to ARITH; 00 or 11 SHALL go directly to SHIFT.
REQ-022 ARITH: exactly one of add/sub, per the latched op, SHALL be high for one cycle; next state SHALL be SHIFT.
REQ-023 SHIFT: shift SHALL be high for one cycle and count SHALL decrement; if count was 1, next state SHALL be DONE, otherwise EVAL.
REQ-024 DONE: done SHALL be 1 and busy SHALL be 0; the FSM SHALL return to IDLE only when start=0 is sampled, so a held start never relaunches.
REQ-025 busy SHALL be 1 in LOAD, EVAL, ARITH and SHIFT, and 0 otherwise.
REQ-026 At most one of add, sub and shift SHALL be high in any cycle; the load/clear strobes SHALL never coincide with add, sub or shift.
REQ-027 Latency: with the start-sampling edge as cycle 0, done SHALL first be high in cycle 2N+2 (no ARITH cycles) to 3N+2 (N ARITH cycles); for N=4 this is cycle 10 to 14.
REQ-028 start SHALL be ignored in LOAD, EVAL, ARITH and SHIFT; q0 and q_1 SHALL be ignored outside EVAL.
REQ-029 count SHALL never wrap below 0 and SHALL hold 0 in DONE and IDLE.

Reset
REQ-030 rst=0 SHALL immediately, without waiting for a clock, force state IDLE, count 0, op cleared, and all outputs 0.
REQ-031 A reset asserted mid-operation SHALL abort the operation; after rst returns to 1, no strobe SHALL issue until a new start is sampled in IDLE.

Verification
REQ-032 Bench SHALL check: start pulse with {q0,q_1}=00 at every EVAL -> 4 shift pulses, no add/sub, done high in cycle 10.
REQ-033 Bench SHALL check: {q0,q_1} sequence 10,01,10,01 -> sub,shift,add,shift,sub,shift,add,shift, done high in cycle 14.
REQ-034 Bench SHALL check: start held at 1 through DONE -> done stays 1 and no LOAD occurs; start=0 -> IDLE next cycle.
REQ-035 Bench SHALL check: start toggled during busy -> no effect; sequence and count identical to the undisturbed run.
REQ-036 Bench SHALL check: rst=0 asserted in ARITH of iteration 2 -> add/sub/busy drop to 0 immediately, count=0; after release, outputs stay idle until start.
REQ-037 Bench SHALL check: mixed pattern 11,01,00,10 -> shift,add,shift,shift,sub,shift; count reads 4,3,2,1,0 across SHIFT decrements.

Source files
------------

// File: rtl/mult_control.sv
// Sequencer for a radix-2 Booth multiplier datapath: issues load/clear,
// add/sub and shift strobes for N iterations, then holds done until start drops.
module mult_control #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          q0,
  input  logic          q_1,
  output logic          load_m,
  output logic          load_q,
  output logic          clr_a,
  output logic          clr_q1,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    ARITH,
    SHIFT,
    DONE
  } state_t;

  state_t state;

  // Outputs are registered together with the next state, so each strobe is
  // high exactly while the FSM sits in the state that owns it. The add/sub
  // registers double as the latched Booth operation for the ARITH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      load_m <= 1'b0;
      load_q <= 1'b0;
      clr_a  <= 1'b0;
      clr_q1 <= 1'b0;
      add    <= 1'b0;
      sub    <= 1'b0;
      shift  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      load_m <= 1'b0;
      load_q <= 1'b0;
      clr_a  <= 1'b0;
      clr_q1 <= 1'b0;
      add    <= 1'b0;
      sub    <= 1'b0;
      shift  <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state  <= LOAD;
            load_m <= 1'b1;
            load_q <= 1'b1;
            clr_a  <= 1'b1;
            clr_q1 <= 1'b1;
            busy   <= 1'b1;
            count  <= CW'(N);
          end
        end
        LOAD: begin
          state <= EVAL;
          busy  <= 1'b1;
        end
        EVAL: begin
          busy <= 1'b1;
          unique case ({q0, q_1})
            2'b10: begin
              state <= ARITH;
              sub   <= 1'b1;
            end
            2'b01: begin
              state <= ARITH;
              add   <= 1'b1;
            end
            default: begin
              state <= SHIFT;
              shift <= 1'b1;
            end
          endcase
        end
        ARITH: begin
          state <= SHIFT;
          shift <= 1'b1;
          busy  <= 1'b1;
        end
        SHIFT: begin
          if (count != '0) count <= count - CW'(1);
          if (count <= CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= EVAL;
            busy  <= 1'b1;
          end
        end
        DONE: begin
          busy <= 1'b0;
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control: a per-cycle strobe trace is predicted
// from the Booth sequencing rules and compared by an independent monitor.
module tb_mult_control;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          q0 = 1'b0;
  logic          q_1 = 1'b0;
  logic          load_m, load_q, clr_a, clr_q1, add, sub, shift, busy, done;
  logic [CW-1:0] count;

  mult_control #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .q_1(q_1),
    .load_m(load_m), .load_q(load_q), .clr_a(clr_a), .clr_q1(clr_q1),
    .add(add), .sub(sub), .shift(shift), .busy(busy), .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // {load_m,load_q,clr_a,clr_q1,add,sub,shift,busy,done,count}
  logic [11:0]  sb_q[$];
  int unsigned  done_q[$];
  logic         done_d = 1'b0;

  function automatic logic [11:0] outs();
    return {load_m, load_q, clr_a, clr_q1, add, sub, shift, busy, done, count};
  endfunction

  function automatic logic [11:0] mk(logic ld, logic a, logic s, logic sh,
                                     logic b, logic d, int c);
    return {ld, ld, ld, ld, a, s, sh, b, d, 3'(c)};
  endfunction

  // Monitor: every cycle in which the DUT shows any activity consumes one
  // predicted vector; activity with nothing predicted is itself an error.
  always @(negedge clk) begin
    logic [11:0] got, exp;
    int unsigned want;
    got = outs();
    if (rst && got != '0) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_activity cyc=%0d got=%b expected idle", cyc, got);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL trace cyc=%0d got=%b expected=%b", cyc, got, exp);
        end
      end
    end
    if (done && !done_d) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        want = done_q.pop_front();
        if (cyc != want) begin
          failures++;
          $display("FAIL done_latency got_cyc=%0d expected_cyc=%0d", cyc, want);
        end
      end
    end
    done_d = done;
  end

  task automatic check_idle(input string name);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL %s got=%b expected=000000000000", name, outs());
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      {q0, q_1} = 2'($urandom);
    end
  endtask

  // One multiplication. hold_extra: extra DONE cycles with start still high.
  // abort_iter: iteration (0-based) whose ARITH cycle gets an async reset.
  task automatic run_op(input logic [1:0] pat [N], input bit toggle,
                        input int hold_extra, input int abort_iter);
    logic [11:0] vecs[$];
    logic [2:0]  drv[$];
    int          narith = 0;
    int          abort_k = -1;
    int          done_first;
    int unsigned s;
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, N));
    drv.push_back(3'b000);
    for (int i = 0; i < N; i++) begin
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, N - i));
      drv.push_back({1'b1, pat[i]});
      if (pat[i] == 2'b10 || pat[i] == 2'b01) begin
        if (i == abort_iter) abort_k = vecs.size();
        vecs.push_back(mk(0, pat[i] == 2'b01, pat[i] == 2'b10, 0, 1, 0, N - i));
        drv.push_back(3'b000);
        narith++;
      end
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, N - i));
      drv.push_back(3'b000);
    end
    done_first = vecs.size();
    for (int h = 0; h <= hold_extra; h++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      drv.push_back(3'b000);
    end

    @(negedge clk);
    start = 1'b1;
    s = cyc;
    for (int k = 0; k < vecs.size(); k++) begin
      if (abort_k < 0 || k <= abort_k) sb_q.push_back(vecs[k]);
    end
    if (abort_k < 0) done_q.push_back(s + 2 * N + 2 + narith);

    for (int k = 0; k < drv.size(); k++) begin
      @(negedge clk);
      if (drv[k][2]) {q0, q_1} = drv[k][1:0];
      else           {q0, q_1} = 2'($urandom);
      if (k >= done_first)  start = (k - done_first) < hold_extra;
      else if (hold_extra > 0) start = 1'b1;
      else if (toggle)      start = 1'($urandom);
      else                  start = 1'b0;
      if (k == abort_k) begin
        #1 rst = 1'b0;
        #1 check_idle("reset_mid_arith");
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1 check_idle("after_reset_release");
        idle_cycles(5);
        return;
      end
    end
    idle_cycles(2);
  endtask

  logic [1:0] pat [N];

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b1;
    idle_cycles(2);
    check_idle("idle_after_reset");

    pat = '{2'b00, 2'b00, 2'b00, 2'b00};
    run_op(pat, 1'b0, 0, -1);
    pat = '{2'b10, 2'b01, 2'b10, 2'b01};
    run_op(pat, 1'b0, 0, -1);
    pat = '{2'b11, 2'b00, 2'b11, 2'b10};
    run_op(pat, 1'b0, 3, -1);
    pat = '{2'b10, 2'b01, 2'b10, 2'b01};
    run_op(pat, 1'b1, 0, -1);
    pat = '{2'b01, 2'b10, 2'b00, 2'b11};
    run_op(pat, 1'b0, 0, 1);
    pat = '{2'b11, 2'b01, 2'b00, 2'b10};
    run_op(pat, 1'b0, 0, -1);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++) pat[i] = 2'($urandom);
      run_op(pat, 1'($urandom), int'($urandom_range(0, 2)), -1);
    end

    idle_cycles(4);
    checks++;
    if (sb_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d/%0d expected=0/0",
               sb_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
